// File: rtl/alu_pkg.sv
// Shared ALU result-stage definitions: select codes, flag bit positions, entry layout.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned FLAG_W     = 4;
    localparam int unsigned RD_W       = 5;

    // Result-select codes driven by the result multiplexer.
    typedef enum logic [1:0] {
        SEL_SUM = 2'b00,
        SEL_XOR = 2'b01,
        SEL_OR  = 2'b10,
        SEL_AND = 2'b11
    } alu_sel_e;

    // Bit positions inside the {N, Z, C, V} flag nibble.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // One stage entry at the default datapath width.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic [FLAG_W-1:0]     flags;
        logic [RD_W-1:0]       rd_addr;
        logic                  rd_we;
    } alu_entry_t;

    // Occupancy of the output register plus skid buffer.
    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } stage_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream and downstream handshake bundle of the ALU result stage.
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [1:0]        in_sel;
    logic              in_cout;
    logic              in_a_msb;
    logic              in_b_msb;
    logic [RD_W-1:0]   in_rd_addr;
    logic              in_rd_we;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [FLAG_W-1:0] out_flags;
    logic [RD_W-1:0]   out_rd_addr;
    logic              out_rd_we;

    // Producer of results and consumer of the writeback side.
    modport master (
        output in_valid, in_result, in_sel, in_cout, in_a_msb, in_b_msb, in_rd_addr, in_rd_we,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_flags, out_rd_addr, out_rd_we
    );

    // The stage itself.
    modport slave (
        input  in_valid, in_result, in_sel, in_cout, in_a_msb, in_b_msb, in_rd_addr, in_rd_we,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_flags, out_rd_addr, out_rd_we
    );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation; C and V only mean something for the adder path.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] result,
    input  logic [1:0]        sel,
    input  logic              cout,
    input  logic              a_msb,
    input  logic              b_msb,
    output logic [FLAG_W-1:0] flags
);

    // Sign and zero always apply; carry/overflow are masked for logic ops.
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[DATA_W-1];
        flags[FLAG_Z] = (result == '0);
        if (sel == SEL_SUM) begin
            flags[FLAG_C] = cout;
            // b_msb is the post-inversion operand, so this also covers subtract.
            flags[FLAG_V] = (a_msb == b_msb) && (result[DATA_W-1] != a_msb);
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// EX-to-writeback register stage with a 2-entry skid buffer and retired-op counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_stage_if.slave bus,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
        logic [RD_W-1:0]   rd_addr;
        logic              rd_we;
    } entry_t;

    stage_state_e      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    entry_t            in_entry, out_q, skid_q;
    logic              load_out_in, load_out_skid, load_skid;
    logic              in_fire, out_fire;
    logic [FLAG_W-1:0] in_flags;
    logic [CNT_W-1:0]  retired_cnt_q;

    alu_flag_gen #(
        .DATA_W (DATA_W)
    ) u_flag_gen (
        .result (bus.in_result),
        .sel    (bus.in_sel),
        .cout   (bus.in_cout),
        .a_msb  (bus.in_a_msb),
        .b_msb  (bus.in_b_msb),
        .flags  (in_flags)
    );

    assign in_entry = '{result: bus.in_result, flags: in_flags,
                        rd_addr: bus.in_rd_addr, rd_we: bus.in_rd_we};

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    // State plus the two handshake flops, all registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next occupancy and which register loads from where.
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d     = StOne;
                    load_out_in = 1'b1;
                end
            end
            StOne: begin
                if (in_fire && !out_fire) begin
                    state_d   = StFull;
                    load_skid = 1'b1;
                end else if (!in_fire && out_fire) begin
                    state_d = StEmpty;
                end else if (in_fire && out_fire) begin
                    load_out_in = 1'b1;
                end
            end
            StFull: begin
                // in_ready_q is low here, so nothing can arrive.
                if (out_fire) begin
                    state_d       = StOne;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Handshake flags follow the next occupancy so they come straight out of flops.
    always_comb begin
        in_ready_d  = (state_d != StFull);
        out_valid_d = (state_d != StEmpty);
    end

    // Output and skid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_in) begin
                out_q <= in_entry;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    // Retired-operation counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
        end else if (out_fire) begin
            retired_cnt_q <= retired_cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_q.result;
    assign bus.out_flags   = out_q.flags;
    assign bus.out_rd_addr = out_q.rd_addr;
    assign bus.out_rd_we   = out_q.rd_we;
    assign retired_cnt     = retired_cnt_q;

endmodule
